oldland_dbus_sram: RTL

Data-bus responder for the Oldland core: the slave end of the word-addressed data bus driven by the memory stage (and debug unit). It decodes a word-address window, services byte-enabled reads and writes against an on-chip single-port RAM after a configurable number of wait states, and terminates every accepted request with exactly one `d_ack` or `d_error` pulse.

---
 rtl/oldland_bus_pkg.sv | 15 +
 rtl/oldland_bram_be.sv | 25 ++
 rtl/oldland_dbus_sram.sv | 116 +++++++++++
 3 files changed

// File: rtl/oldland_bus_pkg.sv
// Shared definitions for the Oldland word-addressed data bus.
// Used by the memory stage, the debug unit and bus responders.
package oldland_bus_pkg;

  localparam int BUS_ADDR_W = 30;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_state_e;

endpackage

// File: rtl/oldland_bram_be.sv
// Single-port RAM with a synchronous read and per-byte write enables.
// Written so that synthesis maps it onto block RAM.
module oldland_bram_be
  import oldland_bus_pkg::*;
#(
  parameter int addr_bits = 10
) (
  input  logic                  clk,
  input  logic [addr_bits-1:0]  addr_i,
  input  logic [BUS_SEL_W-1:0]  we_i,
  input  logic [BUS_DATA_W-1:0] wdata_i,
  output logic [BUS_DATA_W-1:0] rdata_o
);

  logic [BUS_DATA_W-1:0] mem [2**addr_bits];

  // Byte-lane writes plus a registered read of the addressed word
  always_ff @(posedge clk) begin
    for (int i = 0; i < BUS_SEL_W; i++) begin
      if (we_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/oldland_dbus_sram.sv
// Data-bus responder backed by on-chip RAM. Decodes a word-address window,
// commits writes at acceptance, and answers every accepted request with a
// single d_ack or d_error pulse after a fixed number of wait states.
module oldland_dbus_sram
  import oldland_bus_pkg::*;
#(
  parameter int              addr_bits   = 10,
  parameter logic [29:0]     base_word   = 30'h0,
  parameter int              wait_states = 1,
  parameter bit              read_only   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_access,
  input  logic [BUS_ADDR_W-1:0] d_addr,
  input  logic                  d_wr_en,
  input  logic [BUS_SEL_W-1:0]  d_bytesel,
  input  logic [BUS_DATA_W-1:0] d_wr_val,
  output logic [BUS_DATA_W-1:0] d_data,
  output logic                  d_ack,
  output logic                  d_error,
  output logic                  busy
);

  localparam logic [3:0] WAIT_LOAD = (wait_states > 0) ? 4'(wait_states - 1) : 4'd0;

  bus_state_e            state_q;
  logic [3:0]            cnt_q;
  logic                  wr_q;
  logic                  err_q;
  logic [addr_bits-1:0]  addr_q;
  logic                  ack_q;
  logic                  error_q;
  logic                  busy_q;
  logic [BUS_DATA_W-1:0] data_q;

  logic                  hit;
  logic                  req_err;
  logic                  accept;
  logic [BUS_SEL_W-1:0]  ram_we;
  logic [addr_bits-1:0]  ram_addr;
  logic [BUS_DATA_W-1:0] ram_rdata;

  assign hit     = (d_addr >> addr_bits) == (base_word >> addr_bits);
  assign req_err = !hit || (d_wr_en && read_only);
  assign accept  = (state_q == IDLE) && d_access;
  // Writes land in RAM on the acceptance edge, so write data and lanes need no latching.
  assign ram_we  = (accept && d_wr_en && !req_err) ? d_bytesel : '0;
  // While idle the RAM looks at the incoming address so the read starts at
  // acceptance; afterwards it keeps re-reading the latched word.
  assign ram_addr = (state_q == IDLE) ? d_addr[addr_bits-1:0] : addr_q;

  oldland_bram_be #(
    .addr_bits(addr_bits)
  ) u_ram (
    .clk     (clk),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .wdata_i (d_wr_val),
    .rdata_o (ram_rdata)
  );

  // Request address latch; data path only, no reset needed
  always_ff @(posedge clk) begin
    if (accept) addr_q <= d_addr[addr_bits-1:0];
  end

  // Transaction FSM with registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      ack_q   <= 1'b0;
      error_q <= 1'b0;
      data_q  <= '0;
      case (state_q)
        IDLE: begin
          busy_q <= d_access;
          if (d_access) begin
            wr_q  <= d_wr_en;
            err_q <= req_err;
            cnt_q <= WAIT_LOAD;
            if (wait_states > 0) state_q <= WAIT;
            else                 state_q <= RESP;
          end
        end
        WAIT: begin
          busy_q <= 1'b1;
          if (cnt_q == 4'd0) state_q <= RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        RESP: begin
          busy_q  <= 1'b1;
          ack_q   <= !err_q;
          error_q <= err_q;
          if (!err_q && !wr_q) data_q <= ram_rdata;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign d_ack   = ack_q;
  assign d_error = error_q;
  assign d_data  = data_q;
  assign busy    = busy_q;

endmodule
